edge_walker: RTL and testbench
==============================

# edge_walker

Polyline sequencer that feeds the Bresenham interpolator and consumes its output. Accepts a stream of vertices with monotonically increasing x, loads one segment at a time into the interpolator, steps it, and emits a single ordered pixel stream (x, y) for the whole polyline to the downstream rasterising stage. It turns a mesh edge into per-column y coordinates, one pixel per cycle at full throughput.

## Interface
- No parameters; coordinates are fixed at 11 bits, matching the interpolator.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- v_x, v_y  in  11 each  vertex coordinates
- v_stb  in  1  vertex valid
- v_last  in  1  marks the final vertex of the polyline, qualified by v_stb
- v_ack  out  1  vertex accepted this cycle (combinational)
- i_x1, i_y1, i_x2, i_y2  out  11 each  segment endpoints to the interpolator (registered)
- i_load  out  1  one-cycle interpolator load pulse
- i_ready  in  1  interpolator division complete
- i_x, i_y  in  11 each  current interpolated point
- i_finished  in  1  interpolator at the segment endpoint
- i_next  out  1  step the interpolator (combinational)
- p_x, p_y  out  11 each  output pixel
- p_stb  out  1  pixel valid
- p_last  out  1  final pixel of the polyline
- p_ack  in  1  downstream accepts the pixel
- drop_cnt  out  8  saturating count of rejected vertices

## Operation
- States: IDLE, WAITV, LOAD, DIVW, EMIT, SINGLE.
- IDLE: v_ack = v_stb.
  - On accept, latch the vertex as prev and clear the first flag... more precisely, set first = 1.
  - If v_last is set, go to SINGLE; otherwise go to WAITV.
- WAITV: v_ack = v_stb.
  - If v_x <= prev_x, drop the vertex and increment drop_cnt (saturating at 255); prev is unchanged.
  - If the dropped vertex carried v_last and no segment has been emitted yet, go to SINGLE. If it carried v_last after segments have been emitted, emit nothing more; return to IDLE and assert p_last with no pixel (see Timing).
  - Otherwise set i_x1/i_y1 = prev and i_x2/i_y2 = the vertex, record last_seg = v_last, and go to LOAD.
- LOAD: i_load = 1 for exactly one cycle, then go to DIVW.
- DIVW: i_ready is ignored on the first DIVW cycle. Afterwards, i_ready = 1 moves the block to EMIT.
- EMIT:
  - p_x/p_y = i_x/i_y and p_stb = 1, except when the point is suppressed (see Configuration).
  - On p_ack & ~i_finished: i_next = 1.
  - On p_ack & i_finished:
    - prev = (i_x2, i_y2) and first = 0.
    - If last_seg, go to IDLE; otherwise go to WAITV.
  - p_last = last_seg & i_finished.
- SINGLE: p_x/p_y = prev, p_stb = 1, p_last = 1. On p_ack, go to IDLE.
- Arithmetic: all coordinates are unsigned 11-bit. x strictly increases within a segment (the interpolator requires x1 < x2). No wraparound is permitted; the v_x <= prev_x check enforces this.

## Timing
- Reset values:
  - State IDLE.
  - p_stb, p_last, i_load, i_next, v_ack all 0.
  - p_x, p_y, i_x1, i_y1, i_x2, i_y2, drop_cnt all 0.
- Reset mid-operation aborts the segment; the interpolator is left as is and is reloaded on the next segment.
- Segment setup latency from vertex accept to the first p_stb: LOAD (1) + DIVW (at least 2) cycles.
- In EMIT, one pixel per cycle while p_ack is held high. i_next is asserted in the same cycle as p_ack, and the interpolator presents the next point on the following edge.
- p_stb remains stable until p_ack; p_x/p_y do not change while p_stb & ~p_ack.
- Dropped v_last after emitted segments: a one-cycle p_stb = 0, p_last = 1 marker is issued. Downstream treats p_last without p_stb as end-of-polyline.
- A pixel is never accepted and a vertex never acked in the same cycle.

## Configuration
- `EDGE_WALKER_ENDPOINT_DEDUP_EN`:
  - Defined: in EMIT with first = 0, the segment's first point (the shared vertex) is suppressed. p_stb = 0 and i_next = 1 for one cycle without waiting for p_ack, so each shared vertex is emitted exactly once.
  - Undefined: every segment emits both endpoints, and shared vertices appear twice.

## Test plan
- Single segment (0,0),(4,2) with v_last → pixels x = 0..4, y = 0,0,1,1,2 (per interpolator rounding); p_last only on (4,2).
- Polyline (0,10),(3,7),(6,7) last, dedup enabled → 7 pixels: x = 0..6, with x = 3 emitted once and y = 7 at x = 3; dedup undefined → 8 pixels, with (3,7) emitted twice.
- Non-monotonic vertex (5,5),(5,9),(8,5) last → (5,9) dropped, drop_cnt = 1; output is segment (5,5)-(8,5) only.
- Single-vertex polyline (100,200) with v_last → exactly one pixel (100,200) with p_last = 1; i_load never pulses.
- Backpressure: drive p_ack in a 1-0-1-0 pattern during segment (0,0),(10,10) → each pixel is held stable until acked, with no skipped or duplicated pixels.
- Assert rst during EMIT of a 20-pixel segment → the next cycle shows the IDLE state and all outputs at 0; a subsequent new polyline streams correctly.

Source files
------------

// File: rtl/edge_walker.sv
`default_nettype none
// ============================================================================
//  Module   : edge_walker
//  Purpose  : Polyline sequencer around a Bresenham interpolator. It accepts
//             vertices with increasing x, loads one segment at a time into the
//             interpolator, steps it, and emits one ordered (x, y) pixel
//             stream for the whole polyline.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             v_x/v_y/v_stb/v_last/v_ack     vertex input handshake
//             i_x1/i_y1/i_x2/i_y2/i_load     segment load to interpolator
//             i_ready/i_x/i_y/i_finished/i_next  interpolator status / step
//             p_x/p_y/p_stb/p_last/p_ack     pixel output handshake
//             drop_cnt            saturating count of rejected vertices
//  Options  : EDGE_WALKER_ENDPOINT_DEDUP_EN - when defined, the shared vertex
//             between consecutive segments is emitted only once.
//  Revision : 1.0 - initial release
// ============================================================================
module edge_walker (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] v_x,
  input  logic [10:0] v_y,
  input  logic        v_stb,
  input  logic        v_last,
  output logic        v_ack,
  output logic [10:0] i_x1,
  output logic [10:0] i_y1,
  output logic [10:0] i_x2,
  output logic [10:0] i_y2,
  output logic        i_load,
  input  logic        i_ready,
  input  logic [10:0] i_x,
  input  logic [10:0] i_y,
  input  logic        i_finished,
  output logic        i_next,
  output logic [10:0] p_x,
  output logic [10:0] p_y,
  output logic        p_stb,
  output logic        p_last,
  input  logic        p_ack,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAITV  = 3'd1,
    LOAD   = 3'd2,
    DIVW   = 3'd3,
    EMIT   = 3'd4,
    SINGLE = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [10:0] prev_x, prev_y;
  logic        first;       // no segment of this polyline has completed yet
  logic        last_seg;    // current segment ends the polyline
  logic        divw_first;  // first DIVW cycle: interpolator status is stale
  logic        end_mark;    // pulses p_last with no pixel after a dropped v_last

  // Control strobes from the combinational process
  logic        accept_first;
  logic        start_seg;
  logic        drop_vtx;
  logic        seg_done;
  logic        set_mark;

`ifdef EDGE_WALKER_ENDPOINT_DEDUP_EN
  logic        at_start;    // interpolator still sits on the segment's first point
`endif

  always_comb begin
    state_nx     = state;
    v_ack        = 1'b0;
    i_load       = 1'b0;
    i_next       = 1'b0;
    p_stb        = 1'b0;
    p_last       = 1'b0;
    p_x          = 11'd0;
    p_y          = 11'd0;
    accept_first = 1'b0;
    start_seg    = 1'b0;
    drop_vtx     = 1'b0;
    seg_done     = 1'b0;
    set_mark     = 1'b0;

    case (state)
      IDLE: begin
        p_last = end_mark;
        v_ack  = v_stb & ~rst;
        if (v_stb) begin
          accept_first = 1'b1;
          state_nx     = v_last ? SINGLE : WAITV;
        end
      end

      WAITV: begin
        v_ack = v_stb & ~rst;
        if (v_stb) begin
          if (v_x <= prev_x) begin
            // Non-increasing x would make a degenerate or reversed segment.
            drop_vtx = 1'b1;
            if (v_last) begin
              if (first) begin
                state_nx = SINGLE;
              end else begin
                set_mark = 1'b1;
                state_nx = IDLE;
              end
            end
          end else begin
            start_seg = 1'b1;
            state_nx  = LOAD;
          end
        end
      end

      LOAD: begin
        i_load   = 1'b1;
        state_nx = DIVW;
      end

      DIVW: begin
        if (!divw_first && i_ready) begin
          state_nx = EMIT;
        end
      end

      EMIT: begin
        p_x = i_x;
        p_y = i_y;
`ifdef EDGE_WALKER_ENDPOINT_DEDUP_EN
        if (!first && at_start) begin
          // Shared vertex was already emitted as the previous segment's end.
          i_next = 1'b1;
        end else
`endif
        begin
          p_stb  = 1'b1;
          p_last = last_seg & i_finished;
          if (p_ack) begin
            if (!i_finished) begin
              i_next = 1'b1;
            end else begin
              seg_done = 1'b1;
              state_nx = last_seg ? IDLE : WAITV;
            end
          end
        end
      end

      SINGLE: begin
        p_x    = prev_x;
        p_y    = prev_y;
        p_stb  = 1'b1;
        p_last = 1'b1;
        if (p_ack) begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_x     <= 11'd0;
      prev_y     <= 11'd0;
      first      <= 1'b1;
      last_seg   <= 1'b0;
      divw_first <= 1'b0;
      end_mark   <= 1'b0;
      i_x1       <= 11'd0;
      i_y1       <= 11'd0;
      i_x2       <= 11'd0;
      i_y2       <= 11'd0;
      drop_cnt   <= 8'd0;
    end else begin
      state      <= state_nx;
      end_mark   <= set_mark;
      divw_first <= (state == LOAD);

      if (accept_first) begin
        prev_x <= v_x;
        prev_y <= v_y;
        first  <= 1'b1;
      end

      if (drop_vtx && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      if (start_seg) begin
        i_x1     <= prev_x;
        i_y1     <= prev_y;
        i_x2     <= v_x;
        i_y2     <= v_y;
        last_seg <= v_last;
      end

      if (seg_done) begin
        prev_x <= i_x2;
        prev_y <= i_y2;
        first  <= 1'b0;
      end
    end
  end

`ifdef EDGE_WALKER_ENDPOINT_DEDUP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      at_start <= 1'b0;
    end else if (start_seg) begin
      at_start <= 1'b1;
    end else if (i_next || seg_done) begin
      at_start <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_edge_walker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_edge_walker
//  Purpose  : Self-checking bench for edge_walker with a behavioural
//             interpolator and a vertex-list reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_edge_walker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] v_x = '0, v_y = '0;
  logic        v_stb = 1'b0, v_last = 1'b0, v_ack;
  logic [10:0] i_x1, i_y1, i_x2, i_y2;
  logic        i_load, i_ready, i_finished, i_next;
  logic [10:0] i_x, i_y;
  logic [10:0] p_x, p_y;
  logic        p_stb, p_last;
  logic        p_ack = 1'b0;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  edge_walker dut (
    .clk(clk), .rst(rst),
    .v_x(v_x), .v_y(v_y), .v_stb(v_stb), .v_last(v_last), .v_ack(v_ack),
    .i_x1(i_x1), .i_y1(i_y1), .i_x2(i_x2), .i_y2(i_y2), .i_load(i_load),
    .i_ready(i_ready), .i_x(i_x), .i_y(i_y), .i_finished(i_finished),
    .i_next(i_next),
    .p_x(p_x), .p_y(p_y), .p_stb(p_stb), .p_last(p_last), .p_ack(p_ack),
    .drop_cnt(drop_cnt)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Ideal line: y rounded to nearest, halves toward y1.
  function automatic int yref(input int x1, input int y1, input int x2,
                              input int y2, input int x);
    int dx, d, ad, off;
    dx  = x2 - x1;
    d   = y2 - y1;
    ad  = (d < 0) ? -d : d;
    if (dx <= 0) return y1;
    off = (2 * (x - x1) * ad + dx - 1) / (2 * dx);
    return (d >= 0) ? y1 + off : y1 - off;
  endfunction

  // ---------------- behavioural interpolator ----------------
  logic [10:0] m_x1 = '0, m_y1 = '0, m_x2 = '0, m_y2 = '0, m_x = '0;
  int          m_cnt = 0;
  logic        m_ready = 1'b0;

  always @(posedge clk) begin
    if (i_load) begin
      m_x1    <= i_x1;
      m_y1    <= i_y1;
      m_x2    <= i_x2;
      m_y2    <= i_y2;
      m_x     <= i_x1;
      m_cnt   <= $urandom_range(1, 4);
      m_ready <= 1'b0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_ready <= 1'b1;
      end
      if (i_next) m_x <= m_x + 11'd1;
    end
  end

  assign i_ready    = m_ready;
  assign i_x        = m_x;
  assign i_y        = 11'(yref(int'(m_x1), int'(m_y1), int'(m_x2), int'(m_y2), int'(m_x)));
  assign i_finished = (m_x == m_x2);

  // ---------------- downstream ack driver ----------------
  int ack_mode = 2;  // 0 random, 1 toggle, 2 always
  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0:       p_ack = 1'($urandom_range(0, 1));
      1:       p_ack = ~p_ack;
      default: p_ack = 1'b1;
    endcase
  end

  // ---------------- reference model ----------------
  typedef struct { int x; int y; bit last; bit marker; } pix_t;
  pix_t exp_q[$];
  int   vx[16];
  int   vy[16];
  int   nv;
  int   exp_loads;
  int   exp_drops = 0;
  int   load_cnt  = 0;
`ifdef EDGE_WALKER_ENDPOINT_DEDUP_EN
  bit   dedup = 1'b1;
`else
  bit   dedup = 1'b0;
`endif

  task automatic push_pix(input int x, input int y, input bit last, input bit marker);
    pix_t e;
    e.x = x; e.y = y; e.last = last; e.marker = marker;
    exp_q.push_back(e);
  endtask

  task automatic build_expected();
    int  px, py, nseg;
    bit  last;
    exp_loads = 0;
    px = vx[0]; py = vy[0]; nseg = 0;
    if (nv == 1) push_pix(px, py, 1'b1, 1'b0);
    for (int k = 1; k < nv; k++) begin
      last = (k == nv - 1);
      if (vx[k] <= px) begin
        if (exp_drops < 255) exp_drops++;
        if (last) begin
          if (nseg == 0) push_pix(px, py, 1'b1, 1'b0);
          else           push_pix(-1, -1, 1'b1, 1'b1);
        end
      end else begin
        exp_loads++;
        for (int x = px; x <= vx[k]; x++) begin
          if (!(dedup && nseg > 0 && x == px))
            push_pix(x, yref(px, py, vx[k], vy[k], x), last && (x == vx[k]), 1'b0);
        end
        nseg++;
        px = vx[k]; py = vy[k];
      end
    end
  endtask

  // ---------------- output monitor ----------------
  bit   mon_en = 1'b0;
  bit   stall_prev = 1'b0;
  int   hx, hy;

  always @(negedge clk) begin
    pix_t e;
    if (mon_en && !rst) begin
      if (stall_prev) begin
        check("hold_stb", int'(p_stb), 1);
        check("hold_x", int'(p_x), hx);
        check("hold_y", int'(p_y), hy);
      end
      if (p_stb && p_ack) begin
        check("pix_vs_vack", int'(v_ack), 0);
        if (exp_q.size() == 0) begin
          check("extra_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pix_x", int'(p_x), e.x);
          check("pix_y", int'(p_y), e.y);
          check("pix_last", int'(p_last), int'(e.last));
        end
      end else if (p_last && !p_stb) begin
        if (exp_q.size() == 0) begin
          check("extra_marker", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("end_marker", int'(e.marker), 1);
        end
      end
      stall_prev = p_stb && !p_ack;
      hx = int'(p_x);
      hy = int'(p_y);
      if (i_load) load_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_vertex(input int x, input int y, input bit last);
    int t;
    t = 0;
    @(posedge clk); #1;
    v_stb = 1'b1; v_x = 11'(x); v_y = 11'(y); v_last = last;
    @(negedge clk);
    while (!v_ack && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("vack_timeout", 0, 1);
    @(posedge clk); #1;
    v_stb = 1'b0; v_last = 1'b0;
  endtask

  task automatic run_poly(input int mode);
    int t;
    build_expected();
    load_cnt = 0;
    ack_mode = mode;
    for (int k = 0; k < nv; k++) send_vertex(vx[k], vy[k], k == nv - 1);
    t = 0;
    while (exp_q.size() > 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    check("load_count", load_cnt, exp_loads);
    check("drop_cnt", int'(drop_cnt), exp_drops);
  endtask

  task automatic set2(input int x0, input int y0, input int x1, input int y1);
    nv = 2; vx[0] = x0; vy[0] = y0; vx[1] = x1; vy[1] = y1;
  endtask

  task automatic set3(input int x0, input int y0, input int x1, input int y1,
                      input int x2, input int y2);
    nv = 3; vx[0] = x0; vy[0] = y0; vx[1] = x1; vy[1] = y1; vx[2] = x2; vy[2] = y2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p_stb"}, int'(p_stb), 0);
    check({tag, "_p_last"}, int'(p_last), 0);
    check({tag, "_i_load"}, int'(i_load), 0);
    check({tag, "_i_next"}, int'(i_next), 0);
    check({tag, "_v_ack"}, int'(v_ack), 0);
    check({tag, "_p_xy"}, int'({p_x, p_y}), 0);
    check({tag, "_i_x1y1"}, int'({i_x1, i_y1}), 0);
    check({tag, "_i_x2y2"}, int'({i_x2, i_y2}), 0);
    check({tag, "_drop_cnt"}, int'(drop_cnt), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t, x, y;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    mon_en = 1'b1;

    set2(0, 0, 4, 2);                 run_poly(2);
    set3(0, 10, 3, 7, 6, 7);          run_poly(0);
    set3(5, 5, 5, 9, 8, 5);           run_poly(2);
    nv = 1; vx[0] = 100; vy[0] = 200; run_poly(2);
    set2(0, 0, 10, 10);               run_poly(1);
    set3(0, 0, 3, 3, 2, 1);           run_poly(0);
    set2(7, 7, 7, 1);                 run_poly(2);

    // Reset in the middle of a long segment
    mon_en = 1'b0;
    ack_mode = 2;
    set2(0, 0, 19, 5);
    send_vertex(vx[0], vy[0], 1'b0);
    send_vertex(vx[1], vy[1], 1'b1);
    t = 0;
    while (!p_stb && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("emit_reached", int'(p_stb), 1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    exp_q.delete();
    exp_drops  = 0;
    stall_prev = 1'b0;
    mon_en     = 1'b1;
    set3(2, 3, 9, 40, 15, 1);         run_poly(0);

    // Random polylines
    for (int r = 0; r < 30; r++) begin
      nv = $urandom_range(1, 6);
      x  = $urandom_range(0, 50);
      for (int k = 0; k < nv; k++) begin
        y = $urandom_range(0, 2047);
        vx[k] = x; vy[k] = y;
        if ($urandom_range(0, 4) == 0) x = (x > 3) ? x - $urandom_range(0, 3) : x;
        else                           x = x + $urandom_range(1, 12);
      end
      run_poly(0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
